// File: rtl/uf_stage_controller_pkg.sv
// Stage word shared by the controller and every processing unit of the
// union-find decoder array. The encodings are the broadcast values.
package uf_stage_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  // Fixed-length stages (loading, grow, streaming correction) last this many cycles.
  localparam int HOLD_CYCLES = 2;

  typedef enum logic [STAGE_WIDTH-1:0] {
    IDLE                 = 3'd0,
    GROW                 = 3'd1,
    MERGE                = 3'd2,
    PEELING              = 3'd3,
    RESULT_VALID         = 3'd4,
    MEASUREMENT_LOADING  = 3'd5,
    STREAMING_CORRECTION = 3'd6
  } stage_e;

endpackage

// File: rtl/uf_stage_controller_or_reduce_reg.sv
// Registered OR reduction of a wide flag vector, one cycle of latency.
// Used to collapse the per-PE busy and odd flags into single bits.
module or_reduce_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_vec,
  output logic             o_any
);

  logic r_any;

  // Capture the reduction so the wide OR tree ends in a flop.
  always_ff @(posedge clk) begin
    if (reset) r_any <= 1'b0;
    else       r_any <= |i_vec;
  end

  assign o_any = r_any;

endmodule

// File: rtl/uf_stage_controller.sv
// Global sequencer for the union-find decoder array: broadcasts the stage
// word, waits for the PE grid to settle after merge and peeling, repeats
// grow/merge rounds while odd clusters remain, then offers the result.
module uf_stage_controller
  import uf_stage_controller_pkg::*;
#(
  parameter int PU_COUNT      = 64,
  parameter int SETTLE_CYCLES = 3,
  parameter int MAX_ITER      = 31,
  parameter int ITER_WIDTH    = 5,
  parameter int STREAMING     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   meas_valid,
  output logic                   meas_ready,
  output logic [STAGE_WIDTH-1:0] global_stage,
  input  logic [PU_COUNT-1:0]    pu_busy,
  input  logic [PU_COUNT-1:0]    pu_odd,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [ITER_WIDTH-1:0]  iteration_count,
  output logic                   decode_error,
  output logic [15:0]            cycle_count
);

  // One counter serves both the settle window and the fixed-length stages,
  // so it must reach whichever limit is larger.
  localparam int CNT_MAX   = (SETTLE_CYCLES > HOLD_CYCLES - 1) ? SETTLE_CYCLES : HOLD_CYCLES - 1;
  localparam int CNT_WIDTH = $clog2(CNT_MAX + 1);

  stage_e                r_stage;
  stage_e                w_next_stage;
  logic [CNT_WIDTH-1:0]  r_stage_cnt;
  logic [ITER_WIDTH-1:0] r_iter;
  logic                  r_error;
  logic [15:0]           r_cycles;
  logic                  w_busy_any_q;
  logic                  w_odd_any_q;
  logic                  w_accept;
  logic                  w_settled;
  logic                  w_hold_done;
  logic                  w_error_exit;

  or_reduce_reg #(.WIDTH(PU_COUNT)) u_busy_or (
    .clk   (clk),
    .reset (reset),
    .i_vec (pu_busy),
    .o_any (w_busy_any_q)
  );

  or_reduce_reg #(.WIDTH(PU_COUNT)) u_odd_or (
    .clk   (clk),
    .reset (reset),
    .i_vec (pu_odd),
    .o_any (w_odd_any_q)
  );

  // Stage register; it is also the broadcast stage word.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (reset) r_stage <= IDLE;
    else       r_stage <= w_next_stage;
  end

  // Next-stage decision from the stage counter and the reduced PE flags.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    w_next_stage = r_stage;
    w_accept     = 1'b0;
    w_error_exit = 1'b0;
    w_settled    = (r_stage_cnt == CNT_WIDTH'(SETTLE_CYCLES)) && !w_busy_any_q;
    w_hold_done  = (r_stage_cnt == CNT_WIDTH'(HOLD_CYCLES - 1));
    unique case (r_stage)
      IDLE: begin
        if (meas_valid) begin
          w_accept     = 1'b1;
          w_next_stage = MEASUREMENT_LOADING;
        end
      end
      MEASUREMENT_LOADING: if (w_hold_done) w_next_stage = GROW;
      GROW:                if (w_hold_done) w_next_stage = MERGE;
      MERGE: begin
        if (w_settled) begin
          if (!w_odd_any_q) begin
            w_next_stage = PEELING;
          end else if (r_iter == ITER_WIDTH'(MAX_ITER)) begin
            w_error_exit = 1'b1;
            w_next_stage = RESULT_VALID;
          end else begin
            w_next_stage = GROW;
          end
        end
      end
      PEELING: begin
        if (w_settled) w_next_stage = (STREAMING != 0) ? STREAMING_CORRECTION : RESULT_VALID;
      end
      STREAMING_CORRECTION: if (w_hold_done) w_next_stage = RESULT_VALID;
      RESULT_VALID:         if (result_ready) w_next_stage = IDLE;
      default:              w_next_stage = IDLE;
    endcase
  end

  // Stage-relative counter: zero on every stage entry, then counts up and saturates.
  always_ff @(posedge clk) begin
    if (reset)                                      r_stage_cnt <= '0;
    else if (w_next_stage != r_stage)               r_stage_cnt <= '0;
    else if (r_stage_cnt != CNT_WIDTH'(CNT_MAX))    r_stage_cnt <= r_stage_cnt + 1'b1;
  end

  // Per-decode statistics: cleared on acceptance, frozen while the result is offered.
  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_iter   <= '0;
      r_error  <= 1'b0;
      r_cycles <= '0;
    end else begin
      if (w_next_stage == GROW && r_stage != GROW) r_iter <= r_iter + 1'b1;
      if (w_error_exit) r_error <= 1'b1;
      if (r_stage != IDLE && r_stage != RESULT_VALID && r_cycles != 16'hFFFF)
        r_cycles <= r_cycles + 16'd1;
    end
  end

  assign global_stage    = r_stage;
  assign meas_ready      = (r_stage == IDLE);
  assign result_valid    = (r_stage == RESULT_VALID);
  assign iteration_count = r_iter;
  assign decode_error    = r_error;
  assign cycle_count     = r_cycles;

endmodule

// File: tb/tb_uf_stage_controller.sv
// Bench for uf_stage_controller. Two instances: A (STREAMING=0, MAX_ITER=4)
// and B (STREAMING=1, MAX_ITER=31). Each decode is planned up front as a
// per-cycle list of expected stage/counters and the PE flags to drive.
module tb_uf_stage_controller;
  import uf_stage_controller_pkg::*;

  localparam int PU         = 64;
  localparam int SETTLE     = 3;
  localparam int MAX_ITER_A = 4;
  localparam int MAX_ITER_B = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst  [2];
  logic                   mv   [2];
  logic                   mr   [2];
  logic [STAGE_WIDTH-1:0] stg  [2];
  logic [PU-1:0]          busy [2];
  logic [PU-1:0]          odd  [2];
  logic                   rv   [2];
  logic                   rr   [2];
  logic [4:0]             itc  [2];
  logic                   derr [2];
  logic [15:0]            cyc  [2];

  uf_stage_controller #(.PU_COUNT(PU), .SETTLE_CYCLES(SETTLE), .MAX_ITER(MAX_ITER_A),
                        .ITER_WIDTH(5), .STREAMING(0)) u_dut_a (
    .clk(clk), .reset(rst[0]), .meas_valid(mv[0]), .meas_ready(mr[0]),
    .global_stage(stg[0]), .pu_busy(busy[0]), .pu_odd(odd[0]), .result_valid(rv[0]),
    .result_ready(rr[0]), .iteration_count(itc[0]), .decode_error(derr[0]), .cycle_count(cyc[0]));

  uf_stage_controller #(.PU_COUNT(PU), .SETTLE_CYCLES(SETTLE), .MAX_ITER(MAX_ITER_B),
                        .ITER_WIDTH(5), .STREAMING(1)) u_dut_b (
    .clk(clk), .reset(rst[1]), .meas_valid(mv[1]), .meas_ready(mr[1]),
    .global_stage(stg[1]), .pu_busy(busy[1]), .pu_odd(odd[1]), .result_valid(rv[1]),
    .result_ready(rr[1]), .iteration_count(itc[1]), .decode_error(derr[1]), .cycle_count(cyc[1]));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    stage_e        st;
    int            iter;
    logic [PU-1:0] busy;
    logic [PU-1:0] odd;
    logic          rdy;
  } step_t;

  step_t plan[$];
  bit    plan_err;
  int    busy_bit = 17;

  function automatic logic [PU-1:0] rand_vec();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [PU-1:0] one_hot(int b);
    logic [PU-1:0] v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // A settle stage ends on the first cycle k >= SETTLE whose previous-cycle
  // busy input was clear (the reduction register adds one cycle of delay).
  function automatic int settle_len(logic [31:0] pat);
    for (int k = SETTLE; k <= 32; k++) if (!pat[k-1]) return k + 1;
    return 34;
  endfunction

  // Busy pattern per settle-stage cycle: bit j set means busy during cycle j.
  function automatic logic [31:0] gen_pat(int mode);
    case (mode)
      0: return 32'h0;
      1: return 32'h3F;          // busy for the first six cycles
      2: return 32'h2;           // one-cycle glitch at cycle 1
      default: begin
        case ($urandom_range(3))
          0:       return 32'h0;
          1:       return (32'h1 << $urandom_range(8)) - 32'h1;
          2:       return 32'h1 << $urandom_range(2);
          default: return $urandom & $urandom & 32'hFFFF;
        endcase
      end
    endcase
  endfunction

  task automatic add_hold(stage_e st, int n, int it);
    step_t s;
    for (int j = 0; j < n; j++) begin
      s.st = st; s.iter = it; s.busy = rand_vec(); s.odd = rand_vec();
      s.rdy = 1'($urandom_range(1));
      plan.push_back(s);
    end
  endtask

  // odd_mode: 0/1 = value seen by the exit decision, 2 = odd is don't-care.
  task automatic add_settle(stage_e st, int it, logic [31:0] pat, int odd_mode);
    step_t s;
    int len = settle_len(pat);
    for (int j = 0; j < len; j++) begin
      s.st   = st;
      s.iter = it;
      s.busy = (j < 32 && pat[j]) ? one_hot(busy_bit) : '0;
      if (odd_mode == 2 || j != len - 2) s.odd = rand_vec();
      else s.odd = (odd_mode == 1) ? one_hot($urandom_range(PU - 1)) : '0;
      s.rdy  = 1'($urandom_range(1));
      plan.push_back(s);
    end
  endtask

  // Rounds 1..n_odd end merge with odd clusters left; abort at the instance's MAX_ITER.
  task automatic build_plan(int d, int n_odd, int merge_mode, int peel_mode, int rdy_wait);
    step_t s;
    int max_iter = (d == 0) ? MAX_ITER_A : MAX_ITER_B;
    int r = 0;
    bit done = 1'b0;
    plan.delete();
    plan_err = 1'b0;
    add_hold(MEASUREMENT_LOADING, 2, 0);
    while (!done) begin
      r++;
      add_hold(GROW, 2, r);
      if (r <= n_odd) begin
        add_settle(MERGE, r, gen_pat(merge_mode), 1);
        if (r == max_iter) begin plan_err = 1'b1; done = 1'b1; end
      end else begin
        add_settle(MERGE, r, gen_pat(merge_mode), 0);
        add_settle(PEELING, r, gen_pat(peel_mode), 2);
        if (d == 1) add_hold(STREAMING_CORRECTION, 2, r);
        done = 1'b1;
      end
    end
    for (int j = 0; j <= rdy_wait; j++) begin
      s.st = RESULT_VALID; s.iter = r; s.busy = rand_vec(); s.odd = rand_vec();
      s.rdy = (j == rdy_wait);
      plan.push_back(s);
    end
  endtask

  task automatic check_idle(int d, string tag);
    check({tag, " stage"}, stg[d], IDLE);
    check({tag, " meas_ready"}, mr[d], 1);
    check({tag, " result_valid"}, rv[d], 0);
  endtask

  task automatic idle_cycles(int d, int n);
    for (int j = 0; j < n; j++) begin
      mv[d] = 1'b0; busy[d] = rand_vec(); odd[d] = rand_vec(); rr[d] = 1'($urandom_range(1));
      @(negedge clk);
      check_idle(d, $sformatf("idle%0d", d));
    end
  endtask

  // Starts a decode from IDLE (at a negedge) and compares every cycle with the plan.
  task automatic run_plan(int d, int reset_at);
    int t_res = -1;
    for (int t = 0; t < plan.size(); t++)
      if (plan[t].st == RESULT_VALID && t_res < 0) t_res = t;
    mv[d] = 1'b1; busy[d] = rand_vec(); odd[d] = rand_vec(); rr[d] = 1'($urandom_range(1));
    @(negedge clk);
    for (int t = 0; t < plan.size(); t++) begin
      check($sformatf("d%0d t%0d stage", d, t), stg[d], plan[t].st);
      check($sformatf("d%0d t%0d iteration_count", d, t), itc[d], plan[t].iter);
      check($sformatf("d%0d t%0d cycle_count", d, t), cyc[d],
            (plan[t].st == RESULT_VALID) ? t_res : t);
      check($sformatf("d%0d t%0d meas_ready", d, t), mr[d], 0);
      check($sformatf("d%0d t%0d result_valid", d, t), rv[d], plan[t].st == RESULT_VALID);
      check($sformatf("d%0d t%0d decode_error", d, t), derr[d],
            plan[t].st == RESULT_VALID && plan_err);
      if (t == reset_at) begin
        rst[d] = 1'b1; mv[d] = 1'b0;
        @(negedge clk);
        rst[d] = 1'b0;
        check_idle(d, "after_reset");
        check("after_reset iteration_count", itc[d], 0);
        check("after_reset decode_error", derr[d], 0);
        check("after_reset cycle_count", cyc[d], 0);
        return;
      end
      mv[d]   = (t == plan.size() - 1) ? 1'b0 : 1'($urandom_range(1));
      busy[d] = plan[t].busy;
      odd[d]  = plan[t].odd;
      rr[d]   = plan[t].rdy;
      @(negedge clk);
    end
    check_idle(d, $sformatf("d%0d end", d));
  endtask

  initial begin
    int idx;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; mv[d] = 1'b0; busy[d] = '0; odd[d] = '0; rr[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_idle(d, "reset");
      check("reset iteration_count", itc[d], 0);
      check("reset decode_error", derr[d], 0);
      check("reset cycle_count", cyc[d], 0);
      rst[d] = 1'b0;
    end
    idle_cycles(0, 2);

    // Clean decode, then two odd merge exits, then busy stretch and glitch.
    build_plan(0, 0, 0, 0, 0);   run_plan(0, -1); idle_cycles(0, 2);
    build_plan(0, 2, 0, 0, 1);   run_plan(0, -1); idle_cycles(0, 2);
    busy_bit = 17;
    build_plan(0, 1, 1, 0, 0);   run_plan(0, -1); idle_cycles(0, 1);
    build_plan(0, 0, 2, 2, 0);   run_plan(0, -1); idle_cycles(0, 1);
    // Odd stuck high: abort after MAX_ITER rounds with decode_error.
    build_plan(0, 99, -1, 0, 2); run_plan(0, -1); idle_cycles(0, 1);
    // Reset in the middle of the third merge.
    build_plan(0, 99, 0, 0, 0);
    idx = -1;
    for (int t = 0; t < plan.size(); t++)
      if (idx < 0 && plan[t].st == MERGE && plan[t].iter == 3) idx = t + 1;
    run_plan(0, idx); idle_cycles(0, 2);

    // Streaming instance: correction stage and a long-held result.
    idle_cycles(1, 1);
    build_plan(1, 0, 0, 0, 10);   run_plan(1, -1); idle_cycles(1, 2);
    build_plan(1, 99, -1, -1, 1); run_plan(1, -1); idle_cycles(1, 1);

    // Randomized decodes on both instances.
    for (int i = 0; i < 40; i++) begin
      int d = i % 2;
      busy_bit = $urandom_range(PU - 1);
      build_plan(d, ($urandom_range(4) == 0) ? 99 : $urandom_range(5), -1, -1, $urandom_range(4));
      run_plan(d, -1);
      idle_cycles(d, $urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uf_stage_controller.md
Name: uf_stage_controller

Overview:
- Global sequencer for the union-find decoder array. It drives the broadcast stage word that every processing unit registers, and collects their busy and odd flags.
- Decides when merge and peeling have converged, iterates grow/merge rounds until no odd cluster remains, then presents a result handshake.
- Sits at the top of the single-FPGA decoder, between the measurement source and the processing-unit grid.

Parameters:
- PU_COUNT, 64, number of processing units whose busy/odd flags are collected.
- STAGE_WIDTH, 3, width of the stage word (from the shared package).
- SETTLE_CYCLES, 3, cycles after stage entry before busy/odd samples are trusted: PE stage register, then PE busy register, then the controller's reduction register.
- MAX_ITER, 31, maximum grow/merge iterations before aborting.
- ITER_WIDTH, 5, width of the iteration counter; must satisfy 2^ITER_WIDTH > MAX_ITER.
- STREAMING, 0, when 1, a STREAMING_CORRECTION stage is inserted after peeling.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- meas_valid  in  1  measurement round available on the PE measurement inputs
- meas_ready  out  1  controller accepts a round; high only in IDLE
- global_stage  out  STAGE_WIDTH  broadcast stage word to all PEs (registered)
- pu_busy  in  PU_COUNT  per-PE busy flag
- pu_odd  in  PU_COUNT  per-PE odd flag
- result_valid  out  1  decode finished; high in RESULT_VALID
- result_ready  in  1  consumer took the result
- iteration_count  out  ITER_WIDTH  grow rounds executed in the current decode
- decode_error  out  1  MAX_ITER reached without convergence; valid with result_valid
- cycle_count  out  16  clk cycles from leaving IDLE to entering RESULT_VALID; saturating

Behaviour:
- Reset: global_stage=IDLE, meas_ready=1, result_valid=0, iteration_count=0, decode_error=0, cycle_count=0, and all internal counters and flags cleared.
- Reset asserted mid-decode returns to IDLE on the next edge. No partial result is ever presented.
- FSM states equal the stage encodings. global_stage is the state register.
- IDLE:
  - meas_valid & meas_ready -> MEASUREMENT_LOADING.
  - iteration_count, decode_error and cycle_count clear on this transition.
- MEASUREMENT_LOADING: held exactly 2 cycles -> GROW.
- GROW:
  - Held exactly 2 cycles, because a PE asserts its increase only on its first GROW cycle.
  - iteration_count increments on GROW entry -> MERGE.
- MERGE:
  - settle_cnt clears on entry and counts up, saturating at SETTLE_CYCLES.
  - busy_any_q <= |pu_busy and odd_any_q <= |pu_odd, both registered every cycle.
  - Exit when settle_cnt==SETTLE_CYCLES and busy_any_q==0.
  - On exit with odd_any_q=1: if iteration_count==MAX_ITER, set decode_error and go to RESULT_VALID; otherwise go to GROW.
  - On exit with odd_any_q=0: go to PEELING.
- PEELING: same settle and busy rule as MERGE; odd is ignored. Exit -> STREAMING_CORRECTION if STREAMING=1, else RESULT_VALID.
- STREAMING_CORRECTION: held exactly 2 cycles -> RESULT_VALID.
- RESULT_VALID:
  - result_valid=1; counters are frozen.
  - result_ready -> IDLE on the next edge.
  - result_ready asserted in the same cycle as entry has no effect until result_valid is visible.
- A busy pulse that drops within the settle window is never sampled as convergence.
- A busy deassertion followed by reassertion after the window delays exit until busy_any_q is 0 again.
- cycle_count saturates at 16'hFFFF; it does not wrap.
- meas_valid outside IDLE is ignored; the source must hold it until meas_ready.

Decomposition:
- Shared package holds STAGE_WIDTH and the stage constants: IDLE=0, GROW=1, MERGE=2, PEELING=3, RESULT_VALID=4, MEASUREMENT_LOADING=5, STREAMING_CORRECTION=6.
- The package must be the same stage definition the PEs include.
- Sub-module or_reduce_reg: registered OR reduction of a PU_COUNT-bit vector with one-cycle latency. It is instantiated twice, for busy and odd.

Test Plan:
- Reset mid-MERGE (iteration_count=3) -> next cycle global_stage=IDLE, meas_ready=1, iteration_count=0, result_valid=0.
- meas_valid with pu_odd=0 and pu_busy=0 -> sequence LOADING x2, GROW x2, MERGE exits after exactly SETTLE_CYCLES, PEELING, RESULT_VALID; iteration_count=1, decode_error=0.
- pu_odd held 1 for the first 2 MERGE exits, then 0 -> 3 GROW entries, iteration_count=3, then PEELING.
- pu_busy[17]=1 for 6 cycles after MERGE entry -> MERGE exits no earlier than cycle 6+2; a 1-cycle busy glitch at cycle 1 does not cause an early exit.
- pu_odd stuck 1 with MAX_ITER=4 -> after iteration 4, RESULT_VALID with decode_error=1 and no PEELING visit.
- STREAMING=1 -> PEELING, then STREAMING_CORRECTION x2, then RESULT_VALID. With result_ready held low for 10 cycles, result_valid stays high and cycle_count stays frozen; IDLE is entered 1 cycle after result_ready rises.
